// File: rtl/difftest_pmu_pkg.sv
// Shared PMU definitions for the difftest mhpmevent-overflow path:
// event index range and the 64-bit snapshot layout handed to the sink.
package difftest_pmu_pkg;

  localparam int MHPM_FIRST = 3;
  localparam int MHPM_LAST  = 31;
  localparam int NUM_MHPM   = 29;

  typedef logic [63:0] ovf_snap_t;

  // Event k+3 lives at bit k+3 of the snapshot; bits 2:0 and 63:32 are reserved zero.
  function automatic ovf_snap_t to_snap(input logic [NUM_MHPM-1:0] of_vec);
    return {32'h0000_0000, of_vec, 3'b000};
  endfunction

endpackage

// File: rtl/difftest_snap_fifo.sv
// Snapshot queue feeding the difftest sink. When full and not draining, a new
// snapshot replaces the newest entry, since every entry is a complete state.
module difftest_snap_fifo
  import difftest_pmu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] push_data,
  input  logic        pop_ready,
  output logic        valid,
  output logic [63:0] head,
  output logic        pop,
  output logic        coalesce
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  ovf_snap_t     mem_r [DEPTH];
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          coalesce_s;
  logic [AW-1:0] last_idx_s;

  // Occupancy flags and the pop / coalesce decisions for this cycle.
  always_comb begin
    empty_s    = (wr_ptr_r == rd_ptr_r);
    full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s      = !empty_s && pop_ready;
    coalesce_s = push && full_s && !pop_s;
    last_idx_s = wr_ptr_r[AW-1:0] - IDX_ONE;
  end

  // Head presentation; the data bus is forced to zero whenever nothing is queued.
  always_comb begin
    valid    = !empty_s;
    pop      = pop_s;
    coalesce = coalesce_s;
    if (!empty_s) begin
      head = mem_r[rd_ptr_r[AW-1:0]];
    end else begin
      head = 64'h0000_0000_0000_0000;
    end
  end

  // Pointer and storage update; a push while full and draining lands in the freed slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW + 1){1'b0}};
      rd_ptr_r <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'h0000_0000_0000_0000;
      end
    end else begin
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push) begin
        if (coalesce_s) begin
          mem_r[last_idx_s] <= push_data;
        end else begin
          mem_r[wr_ptr_r[AW-1:0]] <= push_data;
          wr_ptr_r                <= wr_ptr_r + PTR_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/difftest_mhpm_ovf_collector.sv
// Sticky mhpmevent overflow vector with change-triggered snapshots queued
// towards the difftest DPI sink, one record per enable strobe.
module difftest_mhpm_ovf_collector
  import difftest_pmu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [28:0]       ovf_pulse,
  input  logic              csr_wen,
  input  logic [4:0]        csr_widx,
  input  logic              csr_wof,
  input  logic [7:0]        coreid,
  input  logic              diff_ready,
  output logic              enable,
  output logic              io_valid,
  output logic [63:0]       io_mhpmeventOverflow,
  output logic [7:0]        io_coreid,
  output logic [28:0]       of_vec,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_ONE = DROP_W'(1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [NUM_MHPM-1:0] of_vec_r;
  logic [NUM_MHPM-1:0] next_s;
  logic [NUM_MHPM-1:0] wr_hit_s;
  logic                chg_s;
  logic                coalesce_s;
  logic [DROP_W-1:0]   drop_cnt_r;

  // Next OF state: a hardware wrap always sets, otherwise a matching write replaces the bit.
  always_comb begin
    wr_hit_s = {NUM_MHPM{1'b0}};
    next_s   = of_vec_r;
    for (int k = 0; k < NUM_MHPM; k++) begin
      if (csr_wen && (csr_widx == 5'(k + MHPM_FIRST))) begin
        wr_hit_s[k] = 1'b1;
      end else begin
        wr_hit_s[k] = 1'b0;
      end
      next_s[k] = ovf_pulse[k] | (wr_hit_s[k] ? csr_wof : of_vec_r[k]);
    end
    chg_s = (next_s != of_vec_r);
  end

  // Architectural OF register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      of_vec_r <= {NUM_MHPM{1'b0}};
    end else if (chg_s) begin
      of_vec_r <= next_s;
    end
  end

  // Saturating count of snapshots folded into the newest queue entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (coalesce_s && (drop_cnt_r != DROP_MAX)) begin
      drop_cnt_r <= drop_cnt_r + DROP_ONE;
    end
  end

  difftest_snap_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (chg_s),
    .push_data (to_snap(next_s)),
    .pop_ready (diff_ready),
    .valid     (io_valid),
    .head      (io_mhpmeventOverflow),
    .pop       (enable),
    .coalesce  (coalesce_s)
  );

  assign of_vec    = of_vec_r;
  assign drop_cnt  = drop_cnt_r;
  assign io_coreid = coreid;

endmodule

// File: doc/difftest_mhpm_ovf_collector.md
Name: difftest_mhpm_ovf_collector

Overview:
- Upstream feeder for the difftest mhpmevent-overflow DPI sink.
- Keeps the architectural sticky overflow (OF) vector for mhpmevent3..31. Inputs are counter-wrap pulses from the PMU and CSR software writes.
- Every cycle the vector changes, takes a full 64-bit snapshot and queues it in a small FIFO.
- Drains one snapshot per cycle to the sink's enable/io_valid/io_mhpmeventOverflow/io_coreid ports when the difftest side is ready.

Parameters:
- FIFO_DEPTH, 4, snapshot queue entries (power of two, >=2).
- DROP_W, 16, width of the saturating coalesce counter.

Ports:
- clock  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- ovf_pulse  input  29  bit k = mhpmcounter(k+3) wrapped this cycle.
- csr_wen  input  1  software write of one OF bit this cycle.
- csr_widx  input  5  event index of the write (valid 3..31).
- csr_wof  input  1  new OF value for csr_widx.
- coreid  input  8  static core id.
- diff_ready  input  1  difftest can accept a record this cycle.
- enable  output  1  DPI call strobe to the sink; equals the pop pulse.
- io_valid  output  1  FIFO head valid.
- io_mhpmeventOverflow  output  64  head snapshot; bits 63:32 and 2:0 always 0.
- io_coreid  output  8  equals coreid.
- of_vec  output  29  current architectural OF bits, for the CSR read path.
- drop_cnt  output  DROP_W  number of coalesced snapshots, saturating.

Behaviour:
- Reset (reset=0, async): of_vec=0, FIFO empty, io_valid=0, enable=0, io_mhpmeventOverflow=0, drop_cnt=0. Counter pulses arriving during reset are lost.
- Next-state per bit k: next[k] = ovf_pulse[k] | (wr_hit[k] ? csr_wof : of_vec[k]). wr_hit[k] = csr_wen & (csr_widx == k+3).
- Hardware set beats a simultaneous software clear of the same bit; the bit ends at 1.
- csr_widx outside 3..31: write ignored, no snapshot.
- Change detect: chg = (next != of_vec). On a clock edge with chg=1, of_vec<=next and the snapshot {32'b0, next, 3'b0} is pushed.
- Writes or pulses that leave the vector unchanged (e.g. a pulse on a bit already set) push nothing.
- Latency: a stimulus in cycle t with an empty FIFO gives io_valid=1 in cycle t+1 carrying the new vector.
- Output: io_valid = !empty, and io_mhpmeventOverflow = head entry when io_valid=1, else 0.
- Pop when io_valid & diff_ready. enable = io_valid & diff_ready, combinational.
- The sink sees exactly one enable per record.
- Push and pop in the same cycle: both occur and the count is unchanged. This is legal when full.
- Full with push and no pop: the newest entry (tail-1) is overwritten with the new snapshot. Snapshots are full state, so no final state is lost. drop_cnt increments, saturating at all-ones.
- Empty with no push: io_valid=0.
- No push occurs on the cycle reset deasserts.
- Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full = MSBs differ and LSBs are equal.
- io_coreid is a pass-through; it is not captured per entry.

Decomposition:
- Shared package difftest_pmu_pkg holds:
  - MHPM_FIRST=3, MHPM_LAST=31, NUM_MHPM=29.
  - typedef ovf_snap_t as logic[63:0].
  - function to_snap(of_vec) returning {32'b0, of_vec, 3'b0}.
- One sub-module: difftest_snap_fifo. It is a parameterised FIFO with the overwrite-newest-on-full rule and a coalesce strobe output.
- The top level holds the OF register, next-state logic and drop counter.

Test Plan:
- Reset release, then ovf_pulse[0]=1 for one cycle with diff_ready=1 -> next cycle io_valid=enable=1, io_mhpmeventOverflow=0x8. of_vec=0x1 afterwards, FIFO empty.
- csr_wen=1, csr_widx=5, csr_wof=0 while of_vec bit2 (event 5) is set, in the same cycle as ovf_pulse[2]=1 -> bit stays 1, no snapshot pushed.
- diff_ready=0; pulses on events 3,4,5,6,7 in 5 consecutive cycles (FIFO_DEPTH=4) -> FIFO holds 0x08, 0x18, 0x38, 0xF8 and drop_cnt=1. Then diff_ready=1 -> exactly 4 enables in that order.
- csr_wen with csr_widx=2 and csr_widx=0 (out of range) -> of_vec unchanged, io_valid stays 0.
- FIFO full, diff_ready=1 and a pulse on event 10 in the same cycle -> one pop plus one push. Count stays 4, drop_cnt unchanged, new tail = prior vector | 0x400.
- Assert reset mid-drain with 3 entries queued -> io_valid=0, enable=0, of_vec=0 and drop_cnt=0 asynchronously, with no enable after release.
